// File: rtl/mem_align_unit.sv
// Purpose : turns byte-addressed RV32 loads/stores into word-aligned array beats; a word-crossing access takes two beats.
// Latency : single-beat loads return in the request cycle; split loads return in the following (SECOND) cycle.
// Backpress: stall is high in beat 1 of a split; the request inputs must stay stable until stall drops.
// Ports   : clk/reset (sync, active-high); req_read/req_write/req_addr/req_wdata/req_funct3 from EX/MEM;
//           mem_addr/mem_re/mem_we/mem_wdata/mem_rdata to the data array; load_data/load_valid to writeback;
//           stall to the pipeline; err pulses for an illegal request.
module mem_align_unit #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              err
);

  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [23:0] lo_q, lo_d;     // beat-1 load bytes, already right-aligned
  logic [1:0]  k_q, k_d;       // number of bytes taken in beat 1

  logic [1:0]        off;
  logic [ADDR_W-1:0] base;
  logic [2:0]        size;
  logic [3:0]        mask;
  logic              legal_f3;
  logic              is_req;
  logic              illegal;
  logic              split;
  logic [4:0]        byte_sh;
  logic [4:0]        k_sh;
  logic [DATA_W-1:0] rd_shift;

  assign off      = req_addr[1:0];
  assign base     = {req_addr[ADDR_W-1:2], 2'b00};
  assign is_req   = req_read | req_write;
  assign legal_f3 = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                              : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign illegal  = is_req & ((req_read & req_write) | ~legal_f3);
  // off is at most 3 and size at most 4, so the sum fits in 3 bits
  assign split    = ({1'b0, off} + size) > 3'd4;
  assign byte_sh  = {off, 3'b000};
  assign k_sh     = {k_q, 3'b000};
  assign rd_shift = mem_rdata >> byte_sh;

  always_comb begin
    size = 3'd4;
    mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   begin size = 3'd1; mask = 4'b0001; end
      2'b01:   begin size = 3'd2; mask = 4'b0011; end
      default: begin size = 3'd4; mask = 4'b1111; end
    endcase
  end

  // funct3[2] selects zero-extension; funct3[1:0] selects byte/half/word
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   extend = f3[2] ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   extend = f3[2] ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: extend = raw;
    endcase
  endfunction

  always_comb begin
    state_d    = IDLE;
    lo_d       = lo_q;
    k_d        = k_q;
    mem_addr   = '0;
    mem_re     = 1'b0;
    mem_we     = 4'b0000;
    mem_wdata  = '0;
    load_data  = '0;
    load_valid = 1'b0;
    stall      = 1'b0;
    err        = 1'b0;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          err = 1'b1;
        end else if (is_req) begin
          mem_addr = base;
          if (req_write) begin
            mem_we    = mask << off;   // upper lanes of a split fall off here
            mem_wdata = req_wdata << byte_sh;
          end else begin
            mem_re = 1'b1;
          end
          if (split) begin
            stall   = 1'b1;
            state_d = SECOND;
            k_d     = 2'(3'd4 - {1'b0, off});
            if (req_read) lo_d = rd_shift[23:0];
          end else if (req_read) begin
            load_data  = extend(rd_shift, req_funct3);
            load_valid = 1'b1;
          end
        end
      end
      SECOND: begin
        // a reset landing in beat 2 must not let the second half reach the array
        if (!reset) begin
          mem_addr = base + ADDR_W'(4);
          if (req_write) begin
            mem_we    = mask >> k_q;
            mem_wdata = req_wdata >> k_sh;
          end else begin
            mem_re     = 1'b1;
            load_data  = extend({8'b0, lo_q} | (mem_rdata << k_sh), req_funct3);
            load_valid = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lo_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      k_q     <= k_d;
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        err;

  logic        use_arr;
  logic [31:0] force_rdata;
  logic [31:0] arr [128];      // the data array the DUT drives
  logic [7:0]  ref_mem [512];  // byte-level reference memory

  int n_cmp = 0;
  int n_err = 0;

  mem_align_unit #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .load_data(load_data), .load_valid(load_valid),
    .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = use_arr ? arr[mem_addr[8:2]] : force_rdata;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) arr[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] wd, input logic [31:0] rdat);
    @(posedge clk); #1;
    req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = a; req_wdata = wd; force_rdata = rdat;
    @(negedge clk);
  endtask

  task automatic next_beat(input logic [31:0] rdat);
    @(posedge clk); #1;
    force_rdata = rdat;
    @(negedge clk);
  endtask

  // Reference: byte-granular memory, access of `size` bytes starting at a (mod 512).
  task automatic ref_op(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] wd);
    int size;
    bit bad, split;
    logic [31:0] exp;
    bad = (rd && wr) || (wr && f3 > 3'd2) ||
          (rd && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5));
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    split = !bad && ((int'(a) % 4) + size > 4);
    exp = 32'd0;
    if (!bad && rd) begin
      for (int i = 0; i < size; i++)
        exp = exp | (32'(ref_mem[(int'(a) + i) % 512]) << (8 * i));
      if (!f3[2] && size < 4 && exp[8*size-1])
        exp = exp | ~((32'd1 << (8 * size)) - 32'd1);
    end
    if (!bad && wr)
      for (int i = 0; i < size; i++)
        ref_mem[(int'(a) + i) % 512] = wd[8*i +: 8];
    drive(rd, wr, f3, a, wd, 32'd0);
    if (bad) begin
      chk("rnd_err", {31'd0, err}, 32'd1);
      chk("rnd_noacc", {27'd0, mem_re, mem_we}, 32'd0);
    end else begin
      chk("rnd_stall", {31'd0, stall}, {31'd0, split});
      if (!split && rd) begin
        chk("rnd_valid", {31'd0, load_valid}, 32'd1);
        chk("rnd_data", load_data, exp);
      end
      if (split) begin
        next_beat(32'd0);
        chk("rnd_stall2", {31'd0, stall}, 32'd0);
        if (rd) begin
          chk("rnd_valid2", {31'd0, load_valid}, 32'd1);
          chk("rnd_data2", load_data, exp);
        end
      end
    end
  endtask

  task automatic rand_op();
    bit rd, wr;
    logic [2:0] f3;
    logic [8:0] a;
    int sel;
    sel = int'($urandom_range(0, 15));
    // 32-byte window 0x1F0..0x00F, straddling the address wrap
    a = 9'(496 + $urandom_range(0, 31));
    rd = 1'b0; wr = 1'b0; f3 = 3'd0;
    if (sel < 7) begin
      rd = 1'b1;
      case ($urandom_range(0, 4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
      endcase
    end else if (sel < 14) begin
      wr = 1'b1; f3 = 3'($urandom_range(0, 2));
    end else if (sel == 14) begin
      rd = 1'b1; wr = 1'b1; f3 = 3'($urandom_range(0, 7));
    end else begin
      rd = 1'($urandom_range(0, 1)); wr = !rd;
      if (rd) begin
        case ($urandom_range(0, 2))
          0: f3 = 3'd3; 1: f3 = 3'd6; default: f3 = 3'd7;
        endcase
      end else f3 = 3'($urandom_range(3, 7));
    end
    ref_op(rd, wr, f3, a, $urandom);
  endtask

  initial begin
    use_arr = 1'b0; force_rdata = 32'd0;
    reset = 1'b1; req_read = 1'b0; req_write = 1'b0;
    req_addr = 9'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);
    chk("rst_we", {28'd0, mem_we}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_ldata", load_data, 32'd0);
    chk("rst_lvalid", {31'd0, load_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // aligned LW
    drive(1, 0, 3'b010, 9'h010, 32'd0, 32'h8000_00F0);
    chk("lw_addr", {23'd0, mem_addr}, 32'h010);
    chk("lw_re", {31'd0, mem_re}, 32'd1);
    chk("lw_data", load_data, 32'h8000_00F0);
    chk("lw_valid", {31'd0, load_valid}, 32'd1);
    chk("lw_stall", {31'd0, stall}, 32'd0);

    // LH / LHU at 0x003 (split)
    for (int s = 0; s < 2; s++) begin
      drive(1, 0, (s == 0) ? 3'b001 : 3'b101, 9'h003, 32'd0, 32'hAB00_0000);
      chk("lh_b1_addr", {23'd0, mem_addr}, 32'h000);
      chk("lh_b1_stall", {31'd0, stall}, 32'd1);
      chk("lh_b1_valid", {31'd0, load_valid}, 32'd0);
      next_beat(32'h0000_00CD);
      chk("lh_b2_addr", {23'd0, mem_addr}, 32'h004);
      chk("lh_b2_data", load_data, (s == 0) ? 32'hFFFF_CDAB : 32'h0000_CDAB);
      chk("lh_b2_valid", {31'd0, load_valid}, 32'd1);
      chk("lh_b2_stall", {31'd0, stall}, 32'd0);
    end

    // SW at 0x002 (split)
    drive(0, 1, 3'b010, 9'h002, 32'h1122_3344, 32'd0);
    chk("sw_b1_addr", {23'd0, mem_addr}, 32'h000);
    chk("sw_b1_we", {28'd0, mem_we}, 32'b1100);
    chk("sw_b1_wdata", mem_wdata, 32'h3344_0000);
    chk("sw_b1_stall", {31'd0, stall}, 32'd1);
    next_beat(32'd0);
    chk("sw_b2_addr", {23'd0, mem_addr}, 32'h004);
    chk("sw_b2_we", {28'd0, mem_we}, 32'b0011);
    chk("sw_b2_wdata", mem_wdata, 32'h0000_1122);
    chk("sw_b2_stall", {31'd0, stall}, 32'd0);

    // byte loads at the top address, then a wrapping LW
    drive(1, 0, 3'b100, 9'h1FF, 32'd0, 32'h8012_3456);
    chk("lbu_stall", {31'd0, stall}, 32'd0);
    chk("lbu_data", load_data, 32'h0000_0080);
    drive(1, 0, 3'b000, 9'h1FF, 32'd0, 32'h8012_3456);
    chk("lb_data", load_data, 32'hFFFF_FF80);
    drive(1, 0, 3'b010, 9'h1FE, 32'd0, 32'hBBAA_0000);
    chk("lwwrap_b1_addr", {23'd0, mem_addr}, 32'h1FC);
    chk("lwwrap_b1_stall", {31'd0, stall}, 32'd1);
    next_beat(32'h0000_DDCC);
    chk("lwwrap_b2_addr", {23'd0, mem_addr}, 32'h000);
    chk("lwwrap_b2_data", load_data, 32'hDDCC_BBAA);

    // reset during SECOND of SW at 0x003
    drive(0, 1, 3'b010, 9'h003, 32'hA5A5_A5A5, 32'd0);
    chk("rs_b1_stall", {31'd0, stall}, 32'd1);
    chk("rs_b1_we", {28'd0, mem_we}, 32'b1000);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rs_b2_we", {28'd0, mem_we}, 32'd0);
    chk("rs_b2_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 9'h000; force_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rs_lw_stall", {31'd0, stall}, 32'd0);
    chk("rs_lw_valid", {31'd0, load_valid}, 32'd1);
    chk("rs_lw_data", load_data, 32'h1234_5678);

    // illegal requests
    drive(0, 1, 3'b011, 9'h010, 32'hFFFF_FFFF, 32'd0);
    chk("ill_st_err", {31'd0, err}, 32'd1);
    chk("ill_st_we", {28'd0, mem_we}, 32'd0);
    chk("ill_st_re", {31'd0, mem_re}, 32'd0);
    chk("ill_st_stall", {31'd0, stall}, 32'd0);
    drive(1, 1, 3'b010, 9'h011, 32'hFFFF_FFFF, 32'd0);
    chk("ill_rw_err", {31'd0, err}, 32'd1);
    chk("ill_rw_we", {28'd0, mem_we}, 32'd0);
    chk("ill_rw_re", {31'd0, mem_re}, 32'd0);
    chk("ill_rw_valid", {31'd0, load_valid}, 32'd0);
    drive(0, 0, 3'b000, 9'h000, 32'd0, 32'd0);
    chk("idle_err", {31'd0, err}, 32'd0);
    chk("idle_addr", {23'd0, mem_addr}, 32'd0);

    // randomized phase against the byte-level model
    use_arr = 1'b1;
    for (int w = 0; w < 8; w++)
      ref_op(1'b0, 1'b1, 3'b010, 9'(496 + 4 * w), $urandom);
    for (int n = 0; n < 200; n++)
      rand_op();
    drive(0, 0, 3'b000, 9'h000, 32'd0, 32'd0);
    for (int w = 0; w < 8; w++) begin
      int b;
      b = (496 + 4 * w) % 512;
      chk("mem_word", arr[b / 4],
          {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
